// File: rtl/dac_pkg.sv
// Shared types and constants for the quad 12-bit DAC serial back-end.
// Frame layout is {pad, cmd, addr, sample, pad}, sent MSB first.
package dac_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int FRAME_W  = 32;
   localparam int PAD_HI_W = 8;
   localparam int PAD_LO_W = 4;

   localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
   localparam logic [3:0] CMD_NOP          = 4'hF;
   localparam logic [3:0] ADDR_ALL         = 4'hF;

   function automatic logic [FRAME_W-1:0] frame_word(
      input logic [3:0]  cmd,
      input logic [3:0]  addr,
      input logic [11:0] data
   );
      return {{PAD_HI_W{1'b0}}, cmd, addr, data, {PAD_LO_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dac_spi_tx_sck_divider.sv
// Half-period tick generator for the DAC serial clock.
// Counter is held at zero while disabled so every frame starts aligned.
module sck_divider #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI transmitter for the quad 12-bit DAC: one 32-bit frame per update,
// clear pulse after reset, minimum chip-select high time between frames.
module dac_spi_tx
   import dac_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int CLR_CYCLES  = 16,
   parameter int CS_HIGH_MIN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cmd,
   input  logic [3:0]  in_addr,
   input  logic [11:0] in_data,
   output logic        done,
   output logic        spi_sck,
   output logic        spi_mosi,
   output logic        dac_cs,
   output logic        dac_clr
);

   localparam int CNT_MAX = (CLR_CYCLES > CS_HIGH_MIN) ? CLR_CYCLES : CS_HIGH_MIN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH_MIN - 1);

   state_t             state;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt;
   logic [4:0]         bit_cnt;
   logic [FRAME_W-1:0] shreg;
   logic [FRAME_W-1:0] word;
   logic               shift_en;
   logic               tick;
   logic               accept;
   logic               last_bit;
   logic               cs_d;
   logic               clr_d;
   logic               rdy_d;
   logic               done_d;

   assign word     = frame_word(in_cmd, in_addr, in_data);
   assign shift_en = (state == ST_SHIFT);
   assign accept   = in_valid && in_ready;
   assign last_bit = tick && spi_sck && (bit_cnt == 5'd31);

   sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (shift_en),
      .tick (tick)
   );

   // State, clear/hold counter and the registered pin decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         cnt      <= '0;
         dac_cs   <= 1'b1;
         dac_clr  <= 1'b0;
         in_ready <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_d;
         if (state_d == state && (state == ST_CLEAR || state == ST_HOLD)) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
         dac_cs   <= cs_d;
         dac_clr  <= clr_d;
         in_ready <= rdy_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_CLEAR: if (cnt == CLR_LAST)  state_d = ST_IDLE;
         ST_IDLE:  if (accept)           state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit)         state_d = ST_HOLD;
         ST_HOLD:  if (cnt == HOLD_LAST) state_d = ST_IDLE;
         default:                        state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      cs_d   = (state_d != ST_SHIFT);
      clr_d  = (state_d != ST_CLEAR);
      rdy_d  = (state_d == ST_IDLE);
      done_d = (state == ST_SHIFT) && (state_d == ST_HOLD);
   end

   // shreg holds the bits still to be sent after the one on spi_mosi.
   always_ff @(posedge clk) begin
      if (rst) begin
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (accept) begin
         spi_sck  <= 1'b0;
         spi_mosi <= word[FRAME_W-1];
         bit_cnt  <= '0;
         shreg    <= {word[FRAME_W-2:0], 1'b0};
      end else if (shift_en && tick) begin
         if (!spi_sck) begin
            spi_sck <= 1'b1;
         end else if (bit_cnt == 5'd31) begin
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
         end else begin
            spi_sck  <= 1'b0;
            spi_mosi <= shreg[FRAME_W-1];
            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 5'd1;
         end
      end
   end

endmodule
